// File: rtl/dac_spi_driver_pkg.sv
// Shared DDFS/DAC definitions (package ddfs_pkg): frame layout, FSM states and sample width.
// Used by the DDFS core and by the dac_spi_driver block.
package ddfs_pkg;

  localparam int DAC_DATA_WIDTH = 12;
  localparam int FRAME_BITS     = 16;

  localparam int BIT_AB     = 15;
  localparam int BIT_BUF    = 14;
  localparam int BIT_GA_N   = 13;
  localparam int BIT_SHDN_N = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } spi_state_e;

  // MCP4921-style write command: channel A, buffer, gain (active low), shutdown (active low), data.
  function automatic logic [FRAME_BITS-1:0] dac_frame(
    input logic [DAC_DATA_WIDTH-1:0] sample,
    input logic                      buf_en,
    input logic                      gain_x2,
    input logic                      shutdown_n
  );
    logic [FRAME_BITS-1:0] f;
    f                         = '0;
    f[DAC_DATA_WIDTH-1:0]     = sample;
    f[BIT_AB]                 = 1'b0;
    f[BIT_BUF]                = buf_en;
    f[BIT_GA_N]               = ~gain_x2;
    f[BIT_SHDN_N]             = shutdown_n;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample handshake between the DDFS core (master) and the DAC SPI driver (slave),
// including the DAC configuration bits that are latched with each sample.
interface dac_spi_driver_if;
  import ddfs_pkg::*;

  logic [DAC_DATA_WIDTH-1:0] sample;
  logic                      sample_valid;
  logic                      sample_ready;
  logic                      gain_x2;
  logic                      buf_en;
  logic                      shutdown_n;

  modport master (
    output sample, sample_valid, gain_x2, buf_en, shutdown_n,
    input  sample_ready
  );

  modport slave (
    input  sample, sample_valid, gain_x2, buf_en, shutdown_n,
    output sample_ready
  );

endinterface

// File: rtl/dac_spi_driver_tick_gen.sv
// spi_tick_gen: half-period tick enable for the SPI engine; counts 0..CLK_DIV-1 while
// enabled and fires on the last count. i_clear restarts the count synchronously.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises 12-bit DDFS samples into 16-bit SPI mode-0 frames for an
// MCP4921-class DAC. Define DAC_LDAC_PULSE_EN to drive a low ldac_n pulse during GAP.
//
// state | meaning
// IDLE  | waiting for a sample, sample_ready high
// SETUP | cs_n low, first bit on mosi, one half-period
// SHIFT | 16 bits, sclk high then low for one half-period each
// GAP   | cs_n high for one half-period (ldac_n pulse when enabled)
module dac_spi_driver
  import ddfs_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 4
) (
  input  logic            clk,
  input  logic            rst,
  dac_spi_driver_if.slave bus,
  output logic            o_cs_n,
  output logic            o_sclk,
  output logic            o_mosi,
  output logic            o_ldac_n,
  output logic            o_busy,
  output logic            o_overrun
);

  spi_state_e            r_state, w_next_state;
  logic                  r_phase_hi, w_next_phase_hi;
  logic [4:0]            r_bit_cnt, w_next_bit_cnt;
  logic [FRAME_BITS-1:0] r_shreg, w_next_shreg;
  logic                  r_cs_n, r_sclk, r_mosi, r_busy, r_ready, r_overrun;
  logic                  w_tick, w_accept, w_idle, w_cs_next;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = bus.sample_valid && r_ready;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_idle),
    .i_en    (!w_idle),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next_state    = r_state;
    w_next_phase_hi = r_phase_hi;
    w_next_bit_cnt  = r_bit_cnt;
    w_next_shreg    = r_shreg;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state    = SETUP;
          w_next_shreg    = dac_frame(bus.sample[DATA_WIDTH-1:0], bus.buf_en,
                                      bus.gain_x2, bus.shutdown_n);
          w_next_bit_cnt  = '0;
          w_next_phase_hi = 1'b0;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_next_state    = SHIFT;
          w_next_phase_hi = 1'b1;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          // Data advances on the falling sclk edge so it is stable across the next rising edge.
          if (r_phase_hi) begin
            w_next_phase_hi = 1'b0;
            w_next_shreg    = {r_shreg[FRAME_BITS-2:0], 1'b0};
          end else if (r_bit_cnt == 5'(FRAME_BITS - 1)) begin
            w_next_state    = GAP;
          end else begin
            w_next_phase_hi = 1'b1;
            w_next_bit_cnt  = r_bit_cnt + 5'd1;
          end
        end
      end
      GAP: begin
        if (w_tick) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_cs_next = (w_next_state == SETUP) || (w_next_state == SHIFT);

  // Pins are registered from the next-state decode so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase_hi <= 1'b0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_phase_hi <= w_next_phase_hi;
      r_bit_cnt  <= w_next_bit_cnt;
      r_shreg    <= w_next_shreg;
      r_cs_n     <= !w_cs_next;
      r_sclk     <= (w_next_state == SHIFT) && w_next_phase_hi;
      r_mosi     <= w_cs_next && w_next_shreg[FRAME_BITS-1];
      r_busy     <= (w_next_state != IDLE);
      r_ready    <= (w_next_state == IDLE);
      if (bus.sample_valid && !r_ready) r_overrun <= 1'b1;
    end
  end

`ifdef DAC_LDAC_PULSE_EN
  logic r_ldac_n;

  always_ff @(posedge clk) begin
    if (rst) r_ldac_n <= 1'b1;
    else     r_ldac_n <= (w_next_state != GAP);
  end

  assign o_ldac_n = r_ldac_n;
`else
  // DAC updates on the cs_n rising edge when ldac_n is held low.
  assign o_ldac_n = 1'b0;
`endif

  assign bus.sample_ready = r_ready;
  assign o_cs_n           = r_cs_n;
  assign o_sclk           = r_sclk;
  assign o_mosi           = r_mosi;
  assign o_busy           = r_busy;
  assign o_overrun        = r_overrun;

endmodule
